// File: rtl/usb_bus_pkg.sv
// Shared types and constants for the two-master 8-bit bus arbiter.
package usb_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_USB = 1'b1;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/bus_rr_picker.sv
// Two-way round-robin pick: under contention the side that did not own the bus last wins.
module bus_rr_picker
  import usb_bus_pkg::*;
(
  input  logic cpu_req,
  input  logic usb_req,
  input  logic owner,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = cpu_req | usb_req;
    winner = OWNER_CPU;
    if (cpu_req && usb_req) winner = ~owner;
    else if (usb_req)       winner = OWNER_USB;
  end

endmodule

// File: rtl/usb_bus_arbiter.sv
// CPU / USB-bridge bus arbiter: one access at a time, IDLE -> ACCESS -> RECOVER.
// Optional watchdog on bus_ready enabled by defining USB_BUS_ARB_TIMEOUT_EN.
module usb_bus_arbiter
  import usb_bus_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              usb_req,
  input  logic              usb_we,
  input  logic [ADDR_W-1:0] usb_addr,
  input  logic [DATA_W-1:0] usb_wdata,
  output logic              usb_gnt,
  output logic              usb_done,
  output logic [DATA_W-1:0] usb_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_read,
  output logic              bus_write,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ready,
  output logic              bus_err,
  output logic              owner
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("usb_bus_arbiter: TIMEOUT must be 1..255");
  end

  state_t            state;
  logic              pick_vld;
  logic              pick_usb;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              timeout_hit;
  logic [DATA_W-1:0] ret_data;

  bus_rr_picker u_picker (
    .cpu_req (cpu_req),
    .usb_req (usb_req),
    .owner   (owner),
    .valid   (pick_vld),
    .winner  (pick_usb)
  );

  assign sel_we    = pick_usb ? usb_we    : cpu_we;
  assign sel_addr  = pick_usb ? usb_addr  : cpu_addr;
  assign sel_wdata = pick_usb ? usb_wdata : cpu_wdata;

  // A timed-out read returns all ones; bus_ready takes priority over the watchdog.
  assign ret_data  = bus_ready ? bus_rdata : '1;

`ifdef USB_BUS_ARB_TIMEOUT_EN
  logic [7:0] wd_cnt;
  assign timeout_hit = (wd_cnt == 8'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWNER_USB;
      cpu_gnt   <= 1'b0;
      usb_gnt   <= 1'b0;
      cpu_done  <= 1'b0;
      usb_done  <= 1'b0;
      bus_read  <= 1'b0;
      bus_write <= 1'b0;
      bus_err   <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      cpu_rdata <= '0;
      usb_rdata <= '0;
`ifdef USB_BUS_ARB_TIMEOUT_EN
      wd_cnt    <= 8'd0;
`endif
    end else begin
      cpu_gnt  <= 1'b0;
      usb_gnt  <= 1'b0;
      cpu_done <= 1'b0;
      usb_done <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            owner     <= pick_usb;
            bus_addr  <= sel_addr;
            bus_wdata <= sel_wdata;
            bus_write <= sel_we;
            bus_read  <= ~sel_we;
            cpu_gnt   <= (pick_usb == OWNER_CPU);
            usb_gnt   <= (pick_usb == OWNER_USB);
`ifdef USB_BUS_ARB_TIMEOUT_EN
            wd_cnt    <= 8'd0;
`endif
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (bus_ready || timeout_hit) begin
            if (bus_read) begin
              if (owner == OWNER_USB) usb_rdata <= ret_data;
              else                    cpu_rdata <= ret_data;
            end
            cpu_done  <= (owner == OWNER_CPU);
            usb_done  <= (owner == OWNER_USB);
            bus_err   <= ~bus_ready;
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            state     <= RECOVER;
          end else begin
`ifdef USB_BUS_ARB_TIMEOUT_EN
            wd_cnt <= wd_cnt + 8'd1;
`endif
          end
        end
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_bus_arbiter.sv
// Directed bench for usb_bus_arbiter; watchdog cases run when USB_BUS_ARB_TIMEOUT_EN is defined.
module tb_usb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_req, cpu_we, usb_req, usb_we;
  logic [7:0] cpu_addr, cpu_wdata, usb_addr, usb_wdata;
  logic       cpu_gnt, cpu_done, usb_gnt, usb_done;
  logic [7:0] cpu_rdata, usb_rdata;
  logic [7:0] bus_addr, bus_wdata, bus_rdata;
  logic       bus_read, bus_write, bus_ready, bus_err, owner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  usb_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .usb_req(usb_req), .usb_we(usb_we), .usb_addr(usb_addr), .usb_wdata(usb_wdata),
    .usb_gnt(usb_gnt), .usb_done(usb_done), .usb_rdata(usb_rdata),
    .bus_addr(bus_addr), .bus_read(bus_read), .bus_write(bus_write), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready), .bus_err(bus_err), .owner(owner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL tb_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt_a, cnt_b, both_hi;
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    usb_req = 0; usb_we = 0; usb_addr = 0; usb_wdata = 0;
    bus_rdata = 0; bus_ready = 0;
    #12;
    chk("rst_gnt",    {cpu_gnt, usb_gnt, cpu_done, usb_done}, 0);
    chk("rst_strobe", {bus_read, bus_write, bus_err}, 0);
    chk("rst_owner",  owner, 1);
    chk("rst_data",   {bus_addr, bus_wdata, cpu_rdata, usb_rdata}, 0);
    tick; rst_n = 1'b1;
    tick;

    // CPU read 0x10, two wait cycles, data 0x5A
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    tick;
    chk("t1_gnt",   cpu_gnt, 1);
    chk("t1_read",  {bus_read, bus_write}, 2'b10);
    chk("t1_addr",  bus_addr, 8'h10);
    chk("t1_owner", owner, 0);
    cpu_req = 0; cnt_a = 1;
    tick; cnt_a += bus_read; chk("t1_nodone", cpu_done, 0);
    tick; cnt_a += bus_read;
    bus_ready = 1; bus_rdata = 8'h5A;
    tick; cnt_a += bus_read;
    chk("t1_done",  cpu_done, 1);
    chk("t1_rdata", cpu_rdata, 8'h5A);
    bus_ready = 0;
    tick; cnt_a += bus_read;
    chk("t1_readlen", cnt_a, 3);
    chk("t1_addrhold", bus_addr, 8'h10);

    // USB write 0xA5 to 0x01, ready immediate (and already high in IDLE)
    usb_req = 1; usb_we = 1; usb_addr = 8'h01; usb_wdata = 8'hA5; bus_ready = 1;
    bus_rdata = 8'hEE;
    tick;
    chk("t2_gnt",   usb_gnt, 1);
    chk("t2_write", {bus_read, bus_write}, 2'b01);
    chk("t2_wdata", {bus_addr, bus_wdata}, 16'h01A5);
    chk("t2_owner", owner, 1);
    usb_req = 0;
    tick;
    chk("t2_done",  {usb_done, cpu_done}, 2'b10);
    chk("t2_strb",  bus_write, 0);
    chk("t2_rdata", usb_rdata, 8'h00);
    bus_ready = 0;
    tick;

    // continuous contention, ready immediate: CPU, USB, CPU, USB every 3 cycles
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h20; cpu_wdata = 8'h11;
    usb_req = 1; usb_we = 0; usb_addr = 8'h21; bus_ready = 1;
    both_hi = 0;
    for (int i = 1; i <= 12; i++) begin
      tick;
      chk($sformatf("t3_cgnt%0d", i), cpu_gnt, ((i % 3 == 1) && ((i / 3) % 2 == 0)) ? 1 : 0);
      chk($sformatf("t3_ugnt%0d", i), usb_gnt, ((i % 3 == 1) && ((i / 3) % 2 == 1)) ? 1 : 0);
      both_hi += (bus_read & bus_write);
    end
    chk("t3_bothstrb", both_hi, 0);
    cpu_req = 0; usb_req = 0; bus_ready = 0;

    // cpu_req held one cycle past done, then dropped: exactly one access
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h22; cpu_wdata = 8'h33; bus_ready = 1;
    cnt_a = 0; cnt_b = 0;
    for (int i = 1; i <= 6; i++) begin
      tick;
      cnt_a += cpu_gnt; cnt_b += cpu_done;
      if (i == 3) cpu_req = 0;
    end
    chk("t4_gnts",  cnt_a, 1);
    chk("t4_dones", cnt_b, 1);
    chk("t4_err",   bus_err, 0);
    bus_ready = 0;

    // reset during USB ACCESS
    usb_req = 1; usb_we = 0; usb_addr = 8'h44;
    tick;
    chk("t5_gnt", usb_gnt, 1);
    usb_req = 0;
    tick;
    chk("t5_access", bus_read, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_strb", {bus_read, bus_write}, 0);
    chk("t5_rst_pulse", {cpu_gnt, usb_gnt, cpu_done, usb_done}, 0);
    chk("t5_rst_owner", owner, 1);
    cpu_req = 1; usb_req = 1; cpu_we = 0; usb_we = 0;
    tick;
    chk("t5_in_rst", {cpu_gnt, usb_gnt}, 0);
    rst_n = 1'b1;
    tick;
    chk("t5_first", {cpu_gnt, usb_gnt}, 2'b10);
    chk("t5_owner", owner, 0);
    cpu_req = 0; usb_req = 0; bus_ready = 1;
    tick;
    chk("t5_done", {cpu_done, usb_done}, 2'b10);
    bus_ready = 0;
    tick;

`ifdef USB_BUS_ARB_TIMEOUT_EN
    // watchdog: read never answered
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h30; bus_rdata = 8'h12;
    tick;
    chk("t6_gnt", cpu_gnt, 1);
    cpu_req = 0;
    for (int i = 2; i <= 4; i++) begin
      tick;
      chk($sformatf("t6_wait%0d", i), {cpu_done, bus_err}, 0);
    end
    tick;
    chk("t6_to", {cpu_done, bus_err}, 2'b11);
    chk("t6_ff", cpu_rdata, 8'hFF);
    chk("t6_strb", bus_read, 0);
    tick;
    chk("t6_errpulse", bus_err, 0);
    // ready lands on the timeout edge: ready wins
    cpu_req = 1;
    tick;
    cpu_req = 0;
    tick; tick; tick;
    bus_ready = 1; bus_rdata = 8'h77;
    tick;
    chk("t7_done", {cpu_done, bus_err}, 2'b10);
    chk("t7_rdata", cpu_rdata, 8'h77);
    bus_ready = 0;
    tick;
`else
    // no watchdog: ACCESS waits as long as ready stays low
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h30;
    tick;
    cpu_req = 0;
    cnt_a = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      cnt_a += cpu_done + bus_err;
    end
    chk("t6_nodone", cnt_a, 0);
    chk("t6_held", bus_read, 1);
    bus_ready = 1; bus_rdata = 8'h3C;
    tick;
    chk("t6_done", {cpu_done, bus_err}, 2'b10);
    chk("t6_rdata", cpu_rdata, 8'h3C);
    bus_ready = 0;
    tick;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
